booth_seq_mul: RTL and testbench

BOOTH_SEQ_MUL -- requirements
Module: booth_seq_mul

---
 rtl/booth_seq_mul.sv | 128 ++++++++++++
 tb/tb_booth_seq_mul.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: one Booth digit per CALC cycle, WIDTH/2+1 cycles per product.
// Valid/ready on both sides; product and out_valid hold in DONE until out_ready, and no new request is taken until then.
module booth_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int AW = 2*WIDTH + 4;
  localparam int BW = WIDTH + 3;
  localparam int N  = WIDTH/2 + 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [AW-1:0]      r_a_sh;
  logic [BW-1:0]      r_b_sh;
  logic [AW-1:0]      r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic [2*WIDTH-1:0] r_product;

  logic               w_a_sx;
  logic               w_b_sx;
  logic [AW-1:0]      w_a_ext;
  logic [BW-1:0]      w_b_ext;
  logic [AW-1:0]      w_a2;
  logic [AW-1:0]      w_pp;
  logic [AW-1:0]      w_acc_nxt;

  assign w_a_sx  = signed_mode & a[WIDTH-1];
  assign w_b_sx  = signed_mode & b[WIDTH-1];
  // Multiplicand kept at full accumulator width and shifted by 2 per digit, so the weight 4^i is implicit.
  assign w_a_ext = {{(AW-WIDTH){w_a_sx}}, a};
  // Multiplier carries the implicit zero below bit 0; its low 3 bits are always the current digit.
  assign w_b_ext = {{2{w_b_sx}}, b, 1'b0};
  assign w_a2    = {r_a_sh[AW-2:0], 1'b0};

  always_comb begin
    w_pp = '0;
    case (r_b_sh[2:0])
      3'b001, 3'b010: w_pp = r_a_sh;
      3'b011:         w_pp = w_a2;
      3'b100:         w_pp = -w_a2;
      3'b101, 3'b110: w_pp = -r_a_sh;
      default:        w_pp = '0;
    endcase
  end

  assign w_acc_nxt = r_acc + w_pp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_product   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh     <= w_a_ext;
            r_b_sh     <= w_b_ext;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= CALC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        CALC: begin
          r_acc  <= w_acc_nxt;
          r_a_sh <= r_a_sh << 2;
          r_b_sh <= {{2{r_b_sh[BW-1]}}, r_b_sh[BW-1:2]};
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_product   <= w_acc_nxt[2*WIDTH-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign product   = r_product;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed and randomized bench for booth_seq_mul at WIDTH 16 (directed corners), 8 and 32 (random vs native multiply).
module tb_booth_seq_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=16 instance
  logic        r16_n, v16, rdy16, sm16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  booth_seq_mul #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(r16_n), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16),
    .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .product(p16), .busy(busy16));

  // WIDTH=8 instance
  logic        r8_n, v8, rdy8, sm8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  booth_seq_mul #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(r8_n), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8));

  // WIDTH=32 instance
  logic        r32_n, v32, rdy32, sm32, ov32, or32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  booth_seq_mul #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(r32_n), .in_valid(v32), .in_ready(rdy32), .a(a32), .b(b32),
    .signed_mode(sm32), .out_valid(ov32), .out_ready(or32), .product(p32), .busy(busy32));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];
  time  t_acc16, t_acc8, t_acc32;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic signed [15:0] sp;
    logic        [15:0] up;
    sp = $signed(x) * $signed(y);
    up = x * y;
    return s ? sp : up;
  endfunction

  function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sp;
    logic        [63:0] up;
    sp = $signed(x) * $signed(y);
    up = x * y;
    return s ? sp : up;
  endfunction

  // One WIDTH=16 transaction; hold>0 applies backpressure with a competing request, spur drives out_ready early.
  task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic s,
                      input int hold, input logic spur, output logic [31:0] p);
    int n;
    int lat;
    a16 = x; b16 = y; sm16 = s; v16 = 1'b1; n = 0;
    while (!rdy16 && n < 100) begin @(posedge clk); #1; n++; end
    check("in_ready16", {63'b0, rdy16}, 64'd1);
    @(posedge clk); t_acc16 = $time; #1;
    v16 = 1'b0; a16 = ~x; b16 = x ^ y ^ 16'h5a5a; sm16 = ~s; or16 = spur;
    check("busy16_calc", {63'b0, busy16}, 64'd1);
    check("in_ready16_calc", {63'b0, rdy16}, 64'd0);
    lat = 0;
    while (!ov16 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("lat16", 64'(lat), 64'd9);
    p = p16;
    if (hold > 0) begin
      or16 = 1'b0; v16 = 1'b1; a16 = 16'h0101; b16 = 16'h0202;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check("hold16_product", {32'b0, p16}, {32'b0, p});
        check("hold16_valid", {63'b0, ov16}, 64'd1);
        check("hold16_in_ready", {63'b0, rdy16}, 64'd0);
      end
    end
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    check("consume16_valid", {63'b0, ov16}, 64'd0);
    check("consume16_in_ready", {63'b0, rdy16}, 64'd1);
    check("consume16_busy", {63'b0, busy16}, 64'd0);
    v16 = 1'b0;
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s, output logic [15:0] p);
    int n;
    int lat;
    a8 = x; b8 = y; sm8 = s; v8 = 1'b1; n = 0;
    while (!rdy8 && n < 100) begin @(posedge clk); #1; n++; end
    check("in_ready8", {63'b0, rdy8}, 64'd1);
    @(posedge clk); t_acc8 = $time; #1;
    v8 = 1'b0; a8 = ~x; b8 = ~y; sm8 = ~s;
    lat = 0;
    while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("lat8", 64'(lat), 64'd5);
    p = p8;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic s, output logic [63:0] p);
    int n;
    int lat;
    a32 = x; b32 = y; sm32 = s; v32 = 1'b1; n = 0;
    while (!rdy32 && n < 100) begin @(posedge clk); #1; n++; end
    check("in_ready32", {63'b0, rdy32}, 64'd1);
    @(posedge clk); t_acc32 = $time; #1;
    v32 = 1'b0; a32 = ~x; b32 = ~y; sm32 = ~s;
    lat = 0;
    while (!ov32 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("lat32", 64'(lat), 64'd17);
    p = p32;
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
  endtask

  task automatic test16();
    logic [31:0] p;
    time         t_prev;
    vecs[0]  = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vecs[1]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs[2]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vecs[3]  = '{16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF};
    vecs[4]  = '{16'h8000, 16'hFFFF, 1'b1, 32'h00008000};
    vecs[5]  = '{16'h1234, 16'h0000, 1'b0, 32'h00000000};
    vecs[6]  = '{16'h0000, 16'h8000, 1'b1, 32'h00000000};
    vecs[7]  = '{16'h0003, 16'h0005, 1'b0, 32'h0000000F};
    vecs[8]  = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001};
    vecs[9]  = '{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000};
    vecs[10] = '{16'h00FF, 16'h0100, 1'b0, 32'h0000FF00};
    vecs[11] = '{16'h1234, 16'h5678, 1'b0, 32'h06260060};
    vecs[12] = '{16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA};

    r16_n = 1'b1; v16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; sm16 = 1'b0;
    #1 r16_n = 1'b0;
    #1;
    check("reset16_in_ready", {63'b0, rdy16}, 64'd1);
    check("reset16_out_valid", {63'b0, ov16}, 64'd0);
    check("reset16_busy", {63'b0, busy16}, 64'd0);
    check("reset16_product", {32'b0, p16}, 64'd0);

    // Request already pending when reset releases: taken on the very next edge.
    v16 = 1'b1; a16 = vecs[0].a; b16 = vecs[0].b; sm16 = vecs[0].sm;
    @(posedge clk); #1 r16_n = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 13; i++) begin
      op16(vecs[i].a, vecs[i].b, vecs[i].sm, 0, 1'b0, p);
      check($sformatf("vec16_%0d", i), {32'b0, p}, {32'b0, vecs[i].exp});
      if (i > 0) check("interval16", 64'(t_acc16 - t_prev), 64'd110);
      t_prev = t_acc16;
    end

    op16(16'h0007, 16'h0009, 1'b0, 0, 1'b1, p);
    check("spur_ready16", {32'b0, p}, 64'h3F);

    op16(16'h7FFF, 16'h8000, 1'b1, 20, 1'b0, p);
    check("backpressure16", {32'b0, p}, 64'hC0008000);

    a16 = 16'h1234; b16 = 16'h5678; sm16 = 1'b0; v16 = 1'b1;
    @(posedge clk); #1 v16 = 1'b0;
    check("midcalc16_busy", {63'b0, busy16}, 64'd1);
    repeat (4) @(posedge clk);
    #1 r16_n = 1'b0;
    #1;
    check("midreset16_in_ready", {63'b0, rdy16}, 64'd1);
    check("midreset16_out_valid", {63'b0, ov16}, 64'd0);
    check("midreset16_product", {32'b0, p16}, 64'd0);
    check("midreset16_busy", {63'b0, busy16}, 64'd0);
    @(posedge clk); #1 r16_n = 1'b1;
    op16(16'd3, 16'd5, 1'b0, 0, 1'b0, p);
    check("after_reset16", {32'b0, p}, 64'd15);
  endtask

  task automatic test8();
    logic [7:0]  x, y;
    logic [15:0] p;
    time         t_prev;
    r8_n = 1'b1; v8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
    #1 r8_n = 1'b0;
    @(posedge clk); #1 r8_n = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      if (i == 0) begin x = 8'h80; y = 8'h80; end
      if (i == 1) begin x = 8'hFF; y = 8'hFF; end
      if (i == 2) begin x = 8'h80; y = 8'hFF; end
      if (i == 3) x = 8'h00;
      if (i == 4) y = 8'h00;
      for (int s = 0; s < 2; s++) begin
        op8(x, y, s[0], p);
        check($sformatf("rand8_%0d_s%0d", i, s), {48'b0, p}, {48'b0, ref8(x, y, s[0])});
        if (t_prev != 0) check("interval8", 64'(t_acc8 - t_prev), 64'd70);
        t_prev = t_acc8;
      end
    end
  endtask

  task automatic test32();
    logic [31:0] x, y;
    logic [63:0] p;
    time         t_prev;
    r32_n = 1'b1; v32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0; sm32 = 1'b0;
    #1 r32_n = 1'b0;
    @(posedge clk); #1 r32_n = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 1000; i++) begin
      x = $urandom; y = $urandom;
      if (i == 0) begin x = 32'h80000000; y = 32'h80000000; end
      if (i == 1) begin x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; end
      if (i == 2) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      if (i == 3) x = 32'h0;
      if (i == 4) y = 32'h0;
      for (int s = 0; s < 2; s++) begin
        op32(x, y, s[0], p);
        check($sformatf("rand32_%0d_s%0d", i, s), p, ref32(x, y, s[0]));
        if (t_prev != 0) check("interval32", 64'(t_acc32 - t_prev), 64'd190);
        t_prev = t_acc32;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      test16();
      test8();
      test32();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
